// File: rtl/zap_copro_responder_pkg.sv
// Shared definitions for the coprocessor responder: mode codes, field
// positions of the MCR/MRC encoding, FSM state encoding and the banked
// register index translation also used by the core's register file.
package zap_copro_responder_pkg;

  localparam logic [4:0] MODE_USR = 5'b10000;
  localparam logic [4:0] MODE_FIQ = 5'b10001;
  localparam logic [4:0] MODE_IRQ = 5'b10010;
  localparam logic [4:0] MODE_SVC = 5'b10011;
  localparam logic [4:0] MODE_ABT = 5'b10111;
  localparam logic [4:0] MODE_UND = 5'b11011;

  // MCR/MRC field positions (LSB of each field)
  localparam int CRM_LSB  = 0;   // [3:0]
  localparam int BIT4_POS = 4;   // must be 1 for register transfer
  localparam int OPC2_LSB = 5;   // [7:5]
  localparam int CPN_LSB  = 8;   // [11:8]
  localparam int RD_LSB   = 12;  // [15:12]
  localparam int CRN_LSB  = 16;  // [19:16]
  localparam int L_POS    = 20;  // 1=MRC, 0=MCR
  localparam int OPC1_LSB = 21;  // [23:21]
  localparam int CLS_LSB  = 24;  // [27:24] == 4'b1110

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_RD_REQ, S_RD_CAP, S_WR_REG, S_DONE
  } copro_state_t;

  // Architectural Rd + mode -> physical register index.
  // r0..r15 map to 0..15; banked copies live above 15:
  // FIQ r8..r14 -> 16..22, IRQ r13/r14 -> 23/24, SVC -> 25/26,
  // ABT -> 27/28, UND -> 29/30.
  function automatic logic [7:0] translate(input logic [3:0] rd, input logic [4:0] mode);
    logic hi;
    hi = (rd == 4'd13) || (rd == 4'd14);
    translate = {4'd0, rd};
    case (mode)
      MODE_FIQ: if (rd >= 4'd8 && rd <= 4'd14) translate = {4'd0, rd} + 8'd8;
      MODE_IRQ: if (hi) translate = {4'd0, rd} + 8'd10;
      MODE_SVC: if (hi) translate = {4'd0, rd} + 8'd12;
      MODE_ABT: if (hi) translate = {4'd0, rd} + 8'd14;
      MODE_UND: if (hi) translate = {4'd0, rd} + 8'd16;
      default: ;
    endcase
  endfunction

endpackage

// File: rtl/zap_copro_regbank.sv
// Coprocessor register bank: NUM_CREGS x 32, c0 is the constant CP_ID,
// single write port, all registers exposed on a flat read bus.
// Ports: clk, rst (async high), we/waddr/wdata write port,
//        creg_flat (c0 in [31:0]).
module zap_copro_regbank #(
  parameter int          NUM_CREGS = 16,
  parameter logic [31:0] CP_ID     = 32'h4100_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [3:0]              waddr,
  input  logic [31:0]             wdata,
  output logic [NUM_CREGS*32-1:0] creg_flat
);

  for (genvar g = 0; g < NUM_CREGS; g++) begin : g_creg
    if (g == 0) begin : g_id
      // c0 is read-only; writes to it are silently dropped
      assign creg_flat[31:0] = CP_ID;
    end else begin : g_rw
      logic [31:0] q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)                         q <= '0;
        else if (we && waddr == 4'(g))   q <= wdata;
      end
      assign creg_flat[g*32 +: 32] = q;
    end
  end

endmodule

// File: rtl/zap_copro_responder.sv
// Coprocessor end of the predecode handshake. Latches the word offered on
// i_copro_dav/i_copro_word, decodes MCR/MRC, moves data between the CPU
// register file side port and the CP register bank, then raises
// o_copro_done until the CPU drops dav.
// Ports: i_clk, i_reset (async high); i_copro_dav/i_copro_word/o_copro_done
//        handshake; i_cpu_mode_mode CPSR mode; o_reg_en/o_reg_wr/o_reg_indx/
//        o_reg_wr_data/i_reg_rd_data regfile side port; o_creg_flat CP regs;
//        o_err one-cycle pulse for requests completed as NOP.
module zap_copro_responder
  import zap_copro_responder_pkg::*;
#(
  parameter int          CP_NUM    = 15,
  parameter int          NUM_CREGS = 16,
  parameter int          PHY_REGS  = 46,
  parameter logic [31:0] CP_ID     = 32'h4100_0000
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_copro_dav,
  input  logic [31:0]                 i_copro_word,
  input  logic [4:0]                  i_cpu_mode_mode,
  output logic                        o_copro_done,
  output logic                        o_reg_en,
  output logic                        o_reg_wr,
  output logic [$clog2(PHY_REGS)-1:0] o_reg_indx,
  output logic [31:0]                 o_reg_wr_data,
  input  logic [31:0]                 i_reg_rd_data,
  output logic [NUM_CREGS*32-1:0]     o_creg_flat,
  output logic                        o_err
);

  localparam int IDXW = $clog2(PHY_REGS);

  copro_state_t state;
  logic [27:0]  word_q;   // condition field is the CPU's business
  logic         unused_cond;
  assign unused_cond = ^i_copro_word[31:28];

  logic [3:0] crn, rd;
  logic       is_xfer, valid;
  logic [31:0] creg_sel;

  assign crn = word_q[CRN_LSB +: 4];
  assign rd  = word_q[RD_LSB  +: 4];

  always_comb begin
    is_xfer = (word_q[CLS_LSB +: 4] == 4'b1110) && word_q[BIT4_POS];
    valid   = is_xfer
           && (word_q[CPN_LSB +: 4]  == 4'(CP_NUM))
           && (word_q[OPC1_LSB +: 3] == 3'd0)
           && (word_q[OPC2_LSB +: 3] == 3'd0)
           && (word_q[CRM_LSB +: 4]  == 4'd0)
           && (rd != 4'hF)
           && (int'(crn) < NUM_CREGS)
           && (i_cpu_mode_mode != MODE_USR);
  end

  always_comb begin
    creg_sel = '0;
    for (int i = 0; i < NUM_CREGS; i++)
      if (crn == 4'(i)) creg_sel = o_creg_flat[i*32 +: 32];
  end

  // CP write only happens if the CPU is still holding the request
  logic cp_we;
  assign cp_we = (state == S_RD_CAP) && i_copro_dav;

  zap_copro_regbank #(.NUM_CREGS(NUM_CREGS), .CP_ID(CP_ID)) u_regbank (
    .clk       (i_clk),
    .rst       (i_reset),
    .we        (cp_we),
    .waddr     (crn),
    .wdata     (i_reg_rd_data),
    .creg_flat (o_creg_flat)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state         <= S_IDLE;
      word_q        <= '0;
      o_copro_done  <= 1'b0;
      o_reg_en      <= 1'b0;
      o_reg_wr      <= 1'b0;
      o_reg_indx    <= '0;
      o_reg_wr_data <= '0;
      o_err         <= 1'b0;
    end else begin
      o_reg_en <= 1'b0;
      o_reg_wr <= 1'b0;
      o_err    <= 1'b0;
      case (state)
        S_IDLE: if (i_copro_dav) begin
          word_q <= i_copro_word[27:0];
          state  <= S_DECODE;
        end
        S_DECODE: begin
          if (!i_copro_dav) state <= S_IDLE;
          else if (!valid) begin
            state        <= S_DONE;
            o_copro_done <= 1'b1;
            o_err        <= 1'b1;
          end else begin
            o_reg_indx <= IDXW'(translate(rd, i_cpu_mode_mode));
            o_reg_en   <= 1'b1;
            if (word_q[L_POS]) begin
              o_reg_wr      <= 1'b1;
              o_reg_wr_data <= creg_sel;
              state         <= S_WR_REG;
            end else begin
              state <= S_RD_REQ;
            end
          end
        end
        S_RD_REQ: state <= i_copro_dav ? S_RD_CAP : S_IDLE;
        // regfile write already issued during WR_REG; abort only skips done
        S_RD_CAP, S_WR_REG: begin
          if (i_copro_dav) begin
            state        <= S_DONE;
            o_copro_done <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        S_DONE: if (!i_copro_dav) begin
          state        <= S_IDLE;
          o_copro_done <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zap_copro_responder.sv
module tb_zap_copro_responder;

  localparam logic [31:0] CPID = 32'h4100_0000;
  localparam logic [4:0]  USR = 5'b10000, IRQ = 5'b10010, SVC = 5'b10011;

  logic         clk = 0, rst = 0, dav = 0;
  logic [31:0]  word = 0, rd_data = 0, reg_wr_data;
  logic [4:0]   mode = SVC;
  logic         done, reg_en, reg_wr, err;
  logic [5:0]   reg_indx;
  logic [511:0] creg_flat;

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  zap_copro_responder dut (
    .i_clk(clk), .i_reset(rst), .i_copro_dav(dav), .i_copro_word(word),
    .i_cpu_mode_mode(mode), .o_copro_done(done), .o_reg_en(reg_en),
    .o_reg_wr(reg_wr), .o_reg_indx(reg_indx), .o_reg_wr_data(reg_wr_data),
    .i_reg_rd_data(rd_data), .o_creg_flat(creg_flat), .o_err(err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] creg(input int n);
    return creg_flat[n*32 +: 32];
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Issue one request and observe it until done (bounded), hold dav for
  // 'hold' extra cycles, then drop dav. Models the regfile read latency:
  // rd_data carries rv only in the cycle after a read enable.
  task automatic op(input string tag, input logic [31:0] w, input logic [4:0] m,
                    input logic [31:0] rv, input int hold,
                    output int dcyc, output int en_n, output logic wr_s,
                    output logic [5:0] ix, output logic [31:0] wd, output int err_n);
    logic prev;
    prev = 0; dcyc = 0; en_n = 0; wr_s = 0; ix = 0; wd = 0; err_n = 0;
    mode = m; word = w; dav = 1;
    for (int c = 1; c <= 8 && dcyc == 0; c++) begin
      tick();
      rd_data = prev ? rv : 32'h0BAD_0BAD;
      prev = reg_en && !reg_wr;
      if (reg_en) begin en_n++; wr_s = reg_wr; ix = reg_indx; wd = reg_wr_data; end
      if (err) err_n++;
      if (done) dcyc = c;
    end
    for (int h = 0; h < hold; h++) begin
      tick();
      chk({tag, "_hold_done"}, done, 1);
      if (reg_en) en_n++;
      if (err) err_n++;
    end
    dav = 0;
    tick();
    chk({tag, "_done_drop"}, done, 0);
    if (reg_en) en_n++;
    if (err) err_n++;
    word = 0;
  endtask

  int d, en, er;
  logic ws;
  logic [5:0] ix;
  logic [31:0] wd;

  initial begin
    rst = 1; #12; rst = 0; #1;
    chk("rst_done", done, 0);   chk("rst_en", reg_en, 0);
    chk("rst_wr", reg_wr, 0);   chk("rst_indx", reg_indx, 0);
    chk("rst_wdata", reg_wr_data, 0); chk("rst_err", err, 0);
    chk("rst_c0", creg(0), CPID);     chk("rst_c3", creg(3), 0);
    tick();

    // MCR p15,0,R2,c3,c0,0 in SVC
    op("mcr_c3", 32'hEE03_2F10, SVC, 32'hDEAD_BEEF, 2, d, en, ws, ix, wd, er);
    chk("mcr_lat", d, 4); chk("mcr_en", en, 1); chk("mcr_wr", ws, 0);
    chk("mcr_indx", ix, 2); chk("mcr_err", er, 0); chk("mcr_c3", creg(3), 32'hDEAD_BEEF);

    // MRC p15,0,R5,c3,c0,0
    op("mrc_c3", 32'hEE13_5F10, SVC, 0, 0, d, en, ws, ix, wd, er);
    chk("mrc_lat", d, 3); chk("mrc_en", en, 1); chk("mrc_wr", ws, 1);
    chk("mrc_indx", ix, 5); chk("mrc_wd", wd, 32'hDEAD_BEEF); chk("mrc_err", er, 0);

    // MRC to banked R13 in SVC -> physical 25
    op("mrc_r13", 32'hEE13_DF10, SVC, 0, 0, d, en, ws, ix, wd, er);
    chk("mrc13_lat", d, 3); chk("mrc13_indx", ix, 25);

    // MCR from user mode: NOP with error
    op("usr", 32'hEE03_2F10, USR, 32'h1111_1111, 0, d, en, ws, ix, wd, er);
    chk("usr_lat", d, 2); chk("usr_en", en, 0); chk("usr_err", er, 1);
    chk("usr_c3", creg(3), 32'hDEAD_BEEF);

    // MCR to coprocessor 14: NOP with error
    op("cp14", 32'hEE03_2E10, SVC, 32'h2222_2222, 0, d, en, ws, ix, wd, er);
    chk("cp14_lat", d, 2); chk("cp14_en", en, 0); chk("cp14_err", er, 1);
    chk("cp14_c3", creg(3), 32'hDEAD_BEEF);

    // MCR to c0 is ignored, MRC c0 returns the ID
    op("mcr_c0", 32'hEE00_2F10, SVC, 32'h1234_5678, 0, d, en, ws, ix, wd, er);
    chk("mcrc0_lat", d, 4); chk("mcrc0_err", er, 0); chk("mcrc0_c0", creg(0), CPID);
    op("mrc_c0", 32'hEE10_5F10, SVC, 0, 0, d, en, ws, ix, wd, er);
    chk("mrcc0_lat", d, 3); chk("mrcc0_wd", wd, CPID); chk("mrcc0_err", er, 0);

    // dav held 10 cycles after done: one execution only
    op("hold", 32'hEE07_2F10, SVC, 32'hCAFE_F00D, 10, d, en, ws, ix, wd, er);
    chk("hold_lat", d, 4); chk("hold_en", en, 1); chk("hold_err", er, 0);
    chk("hold_c7", creg(7), 32'hCAFE_F00D);
    // next word right after a single low cycle; R14 in IRQ -> physical 24
    op("irq", 32'hEE17_EF10, IRQ, 0, 0, d, en, ws, ix, wd, er);
    chk("irq_lat", d, 3); chk("irq_indx", ix, 24); chk("irq_wd", wd, 32'hCAFE_F00D);

    // dav drops while in RD_CAP: no CP write, no done
    mode = SVC; word = 32'hEE04_2F10; dav = 1; rd_data = 32'h5555_5555;
    tick(); tick(); tick();
    dav = 0;
    tick(); chk("abort_done", done, 0);
    tick(); chk("abort_done2", done, 0); chk("abort_c4", creg(4), 0);
    word = 0;

    // reset asserted during RD_CAP clears everything without a clock edge
    word = 32'hEE05_2F10; dav = 1; rd_data = 32'h7777_7777;
    tick(); tick(); tick();
    chk("pre_rst_indx", reg_indx, 2);
    #2 rst = 1; #1;
    chk("arst_indx", reg_indx, 0); chk("arst_wdata", reg_wr_data, 0);
    chk("arst_done", done, 0);     chk("arst_en", reg_en, 0);
    chk("arst_c3", creg(3), 0);    chk("arst_c7", creg(7), 0);
    chk("arst_c0", creg(0), CPID);
    dav = 0;
    tick(); rst = 0;
    tick(); chk("post_rst_c5", creg(5), 0); chk("post_rst_done", done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
